multi_slave_select: RTL
=======================

MULTI_SLAVE_SELECT -- requirements
Module: multi_slave_select

Interface
REQ-001 Parameter NUM_SS, default 4, number of slave-select lines; legal range 1..16.
REQ-002 Parameter FRAME_BITS, default 8, bits per transfer frame; legal range 4..32.
REQ-003 Parameter BRD_W, default 12, width of the baud-rate divisor.
REQ-004 Parameter GAP_W, default 4, width of the inter-frame gap count.
REQ-005 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 preset_n  input  1  asynchronous, active-low reset.
REQ-007 mstr_i  input  1  master mode enable.
REQ-008 spiswai_i  input  1  stop-in-wait control.
REQ-009 spi_mode_i  input  2  00 run, 01 wait, 10/11 stop.
REQ-010 send_data_i  input  1  transfer request, sampled every cycle.
REQ-011 brd_i  input  BRD_W  baud divisor in pclk cycles per bit.
REQ-012 ss_sel_i  input  max(1,clog2(NUM_SS))  target slave index.
REQ-013 cs_gap_i  input  GAP_W  idle cycles forced between frames.
REQ-014 abort_i  input  1  cancels the current frame and any pending request.
REQ-015 ss_o  output  NUM_SS  active-low selects; at most one bit low.
REQ-016 tip_o  output  1  transfer in progress.
REQ-017 r_data_o  output  1  one-cycle frame-complete strobe.
REQ-018 busy_o  output  1  high in ACTIVE or GAP, or while a request is pending.

Function
REQ-019 Define en = mstr_i & ((spi_mode_i==00) | (spi_mode_i==01 & ~spiswai_i)).
REQ-020 FSM states: IDLE, ACTIVE, GAP.
REQ-021 IDLE: on send_data_i & en & (ss_sel_i<NUM_SS), latch sel, brd and gap, then enter ACTIVE on the next edge; ss_o[sel]=0 and tip_o=1 from that edge.
REQ-022 A request with ss_sel_i>=NUM_SS is dropped with no output change.
REQ-023 Frame length target = FRAME_BITS*max(brd,1) pclk cycles; a latched brd of 0 is treated as 1.
REQ-024 Counter width SHALL hold FRAME_BITS*(2^BRD_W-1) without overflow.
REQ-025 ACTIVE: the counter increments each cycle while en=1; while en=0 the counter freezes, ss_o holds and tip_o stays 1 (pause, not abort).
REQ-026 ACTIVE ends when the counter reaches target-1 with en=1; on the next edge ss_o returns to all-ones, tip_o=0 and r_data_o=1 for exactly one cycle.
REQ-027 After ACTIVE ends, the FSM enters GAP if the latched gap>0, otherwise IDLE.
REQ-028 GAP holds ss_o all-ones for exactly the latched gap cycles, then returns to IDLE.
REQ-029 A send_data_i seen in ACTIVE or GAP sets a single pending flag and latches that request's ss_sel_i; further requests overwrite the latched ss_sel_i (depth-1 queue).
REQ-030 In IDLE, a pending flag with en=1 starts a frame exactly as in REQ-021 and clears the flag.
REQ-031 Latched brd and gap are frozen for the duration of a frame; input changes apply to the next frame only.
REQ-032 abort_i=1, or mstr_i=0, in any state: next edge gives IDLE, ss_o all-ones, tip_o=0, pending cleared, no r_data_o strobe.
REQ-033 When abort_i and send_data_i are asserted together, abort wins and no request is recorded.
REQ-034 When the ACTIVE-end cycle coincides with send_data_i, the strobe fires and the request becomes pending.

Reset
REQ-035 preset_n=0 immediately forces IDLE, ss_o all-ones, tip_o=0, r_data_o=0, busy_o=0, pending=0 and counters=0, independent of pclk.
REQ-036 Deasserting reset mid-frame gives no resumption; the block waits for a new request.

Verification
REQ-037 mode 00, sel=2, brd=4, gap=0, one-cycle send -> ss_o=1011 for exactly 32 cycles, tip_o=1 throughout, then a single r_data_o pulse.
REQ-038 Same frame with spi_mode_i switched to 01 and spiswai_i=1 for 10 cycles mid-frame -> ss_o stays low for 42 cycles in total and the strobe is delayed by 10 cycles.
REQ-039 gap=3, send to sel=1 during ACTIVE of a sel=0 frame -> ss_o 1110 frame, 3 cycles of 1111, then a 1101 frame, two strobes.
REQ-040 abort_i at cycle 5 of a brd=4 frame -> ss_o all-ones on the next edge, no strobe, busy_o=0.
REQ-041 preset_n pulsed low between clock edges mid-frame -> outputs reset before the next pclk edge, and the block stays idle afterwards.
REQ-042 brd=0 with FRAME_BITS=8 -> 8-cycle frame; ss_sel_i=5 with NUM_SS=4 -> request ignored.

Source files
------------

// File: rtl/multi_slave_select.sv
// multi_slave_select: frame-timed active-low slave-select sequencer
// with pause, abort, inter-frame gap and a depth-1 request queue.
//
// Ports:
//   pclk, preset_n    clock, async active-low reset
//   mstr_i            master enable (low forces idle)
//   spiswai_i         stop-in-wait
//   spi_mode_i        00 run, 01 wait, 1x stop
//   send_data_i       transfer request
//   brd_i             pclk cycles per bit (0 acts as 1)
//   ss_sel_i          target slave index
//   cs_gap_i          idle cycles between frames
//   abort_i           cancel frame and pending request
//   ss_o              active-low selects
//   tip_o             transfer in progress
//   r_data_o          one-cycle frame-done strobe
//   busy_o            frame, gap or pending request
module multi_slave_select #(
  parameter int NUM_SS     = 4,
  parameter int FRAME_BITS = 8,
  parameter int BRD_W      = 12,
  parameter int GAP_W      = 4,
  localparam int SEL_W     =
    (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              mstr_i,
  input  logic              spiswai_i,
  input  logic [1:0]        spi_mode_i,
  input  logic              send_data_i,
  input  logic [BRD_W-1:0]  brd_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  input  logic [GAP_W-1:0]  cs_gap_i,
  input  logic              abort_i,
  output logic [NUM_SS-1:0] ss_o,
  output logic              tip_o,
  output logic              r_data_o,
  output logic              busy_o
);

  localparam longint MAX_CNT =
    longint'(FRAME_BITS) *
    ((longint'(1) << BRD_W) - 1);
  localparam int CNT_W = $clog2(MAX_CNT + 1);

  localparam logic [SEL_W:0] SS_LIM =
    (SEL_W+1)'(NUM_SS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tgt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] pend_sel_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             pend_q;
  logic             strobe_q;

  logic             en;
  logic             kill;
  logic             sel_ok;
  logic             req_ok;
  logic             have_req;
  logic [SEL_W-1:0] req_sel;
  logic             frame_end;
  logic             gap_end;
  logic             launch;
  logic [BRD_W-1:0] brd_eff;

  assign en = mstr_i &
    ((spi_mode_i == 2'b00) |
     ((spi_mode_i == 2'b01) & ~spiswai_i));

  assign kill   = abort_i | ~mstr_i;
  assign sel_ok = {1'b0, ss_sel_i} < SS_LIM;
  assign req_ok = send_data_i & sel_ok & ~kill;

  // A fresh request overrides an older
  // pending one (depth-1 queue semantics).
  assign have_req = req_ok | pend_q;
  assign req_sel  = req_ok ? ss_sel_i
                           : pend_sel_q;

  assign brd_eff = (brd_i == '0) ? BRD_W'(1)
                                 : brd_i;

  assign frame_end = (state_q == ACTIVE) & en &
                     (cnt_q == tgt_q);

  assign gap_end = (state_q == GAP) &
    (gap_cnt_q == gap_q - GAP_W'(1));

  // A queued request launches straight out of
  // the last gap cycle so the idle time between
  // frames is exactly the programmed gap.
  assign launch = ~kill & en & have_req &
    ((state_q == IDLE) | gap_end);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else if (launch) begin
      state_d = ACTIVE;
    end else if (frame_end) begin
      state_d = (gap_q != '0) ? GAP : IDLE;
    end else if (gap_end) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q      <= '0;
      tgt_q      <= '0;
      sel_q      <= '0;
      pend_sel_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      pend_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= frame_end & ~kill;
      if (kill) begin
        cnt_q     <= '0;
        gap_cnt_q <= '0;
        pend_q    <= 1'b0;
      end else begin
        if (launch) begin
          sel_q <= req_sel;
          tgt_q <= CNT_W'(FRAME_BITS) *
                   CNT_W'(brd_eff) -
                   CNT_W'(1);
          gap_q <= cs_gap_i;
          cnt_q <= '0;
        end else if (frame_end) begin
          cnt_q <= '0;
        end else if (state_q == ACTIVE && en) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end

        if (state_q == GAP && !gap_end) begin
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end else begin
          gap_cnt_q <= '0;
        end

        if (launch) begin
          pend_q <= 1'b0;
        end else if (req_ok && state_q != IDLE) begin
          pend_q     <= 1'b1;
          pend_sel_q <= ss_sel_i;
        end
      end
    end
  end

  always_comb begin
    ss_o = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (state_q == ACTIVE &&
          sel_q == SEL_W'(i)) begin
        ss_o[i] = 1'b0;
      end
    end
    tip_o    = (state_q == ACTIVE);
    r_data_o = strobe_q;
    busy_o   = (state_q != IDLE) | pend_q;
  end

endmodule
